// File: rtl/entrada_clave_pkg.sv
// entrada_clave_pkg: shared state encoding, key codes and timeout default for the keypad entry block
package entrada_clave_pkg;
  localparam logic [1:0] VACIO = 2'd0;
  localparam logic [1:0] UNO   = 2'd1;
  localparam logic [1:0] DOS   = 2'd2;
  localparam logic [3:0] TECLA_BORRAR = 4'hA;
  localparam logic [3:0] TECLA_ENTER  = 4'hB;
  localparam int TIMEOUT_DEF = 1000;
  function automatic logic es_digito(input logic [3:0] k);
    return k < 4'hA;
  endfunction
endpackage

// File: rtl/temporizador_inactividad.sv
// temporizador_inactividad: 16-bit idle counter flagging TIMEOUT-1 idle cycles while enabled
module temporizador_inactividad #(
  parameter int TIMEOUT = 1000
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expirado
);
  logic [15:0] cnt_q;
  logic [15:0] cnt_d;
  assign expirado = enable && (cnt_q == 16'(TIMEOUT - 1));
  assign cnt_d = (!enable || clear || expirado) ? 16'd0 : cnt_q + 16'd1;
  // count idle cycles; any restart condition or expiry returns to zero
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) cnt_q <= 16'd0;
    else cnt_q <= cnt_d;
  end
endmodule

// File: rtl/entrada_clave.sv
// entrada_clave: two-digit keypad code entry with clear, enter, lockout and idle timeout
module entrada_clave
  import entrada_clave_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       kValid,
  input  logic [3:0] kDigit,
  input  logic       sBloq,
  output logic [7:0] sCode,
  output logic       sEnter,
  output logic       sErrTecla,
  output logic [1:0] sDigitos
);
  logic [1:0] st_q, st_d;
  logic [7:0] buf_q, buf_d, code_q, code_d;
  logic       enter_q, enter_d, err_q, err_d;
  logic       expirado;
  temporizador_inactividad #(.TIMEOUT(TIMEOUT)) u_tmr (
    .clock(clock),
    .reset(reset),
    .clear(kValid),
    .enable((st_q != VACIO) && !sBloq),
    .expirado(expirado)
  );
  // next-state: lockout beats keys, keys beat timer expiry
  always_comb begin
    st_d = st_q;
    buf_d = buf_q;
    code_d = code_q;
    enter_d = 1'b0;
    err_d = 1'b0;
    if (sBloq) begin
      st_d = VACIO;
      buf_d = 8'h00;
    end else if (kValid) begin
      if (es_digito(kDigit)) begin
        buf_d = {buf_q[3:0], kDigit};
        st_d = (st_q == VACIO) ? UNO : DOS;
      end else if (kDigit == TECLA_BORRAR) begin
        buf_d = 8'h00;
        st_d = VACIO;
      end else if (kDigit == TECLA_ENTER) begin
        code_d = (st_q == DOS) ? buf_q : code_q;
        enter_d = (st_q == DOS);
        err_d = (st_q != DOS);
        buf_d = 8'h00;
        st_d = VACIO;
      end else err_d = 1'b1;
    end else if (expirado) begin
      buf_d = 8'h00;
      st_d = VACIO;
      err_d = 1'b1;
    end
  end
  // state and registered outputs
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      st_q <= VACIO;
      buf_q <= 8'h00;
      code_q <= 8'h00;
      enter_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      st_q <= st_d;
      buf_q <= buf_d;
      code_q <= code_d;
      enter_q <= enter_d;
      err_q <= err_d;
    end
  end
  assign sCode = code_q;
  assign sEnter = enter_q;
  assign sErrTecla = err_q;
  assign sDigitos = st_q;
endmodule

// File: tb/tb_entrada_clave.sv
// tb_entrada_clave: scenario tasks with a queue of expected submitted codes
module tb_entrada_clave;
  import entrada_clave_pkg::*;
  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       kValid = 1'b0;
  logic [3:0] kDigit = 4'h0;
  logic       sBloq = 1'b0;
  logic [7:0] sCode;
  logic       sEnter, sErrTecla;
  logic [1:0] sDigitos;
  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] exp_q[$];
  logic [7:0] e;

  entrada_clave #(.TIMEOUT(16)) dut (
    .clock(clock), .reset(reset), .kValid(kValid), .kDigit(kDigit), .sBloq(sBloq),
    .sCode(sCode), .sEnter(sEnter), .sErrTecla(sErrTecla), .sDigitos(sDigitos)
  );

  always #5 clock = ~clock;

  // every sEnter pulse must match the oldest queued expected code
  always @(negedge clock) begin
    if (reset && (sEnter || sErrTecla)) begin
      n_cmp++;
      if (sEnter && sErrTecla) begin
        n_bad++;
        $display("FAIL both_strobes: sEnter=%b sErrTecla=%b required not both high", sEnter, sErrTecla);
      end
    end
    if (reset && sEnter) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_enter: sEnter=1 sCode=%h, required no submission", sCode);
      end else begin
        e = exp_q.pop_front();
        if (sCode !== e) begin
          n_bad++;
          $display("FAIL enter_code: sCode=%h required %h", sCode, e);
        end
      end
    end
  end

  task automatic press(input logic [3:0] d);
    kValid = 1'b1;
    kDigit = d;
    @(negedge clock);
    kValid = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    repeat (2) @(negedge clock);
    n_cmp++;
    if ({sCode, sEnter, sErrTecla, sDigitos} !== 12'h000) begin
      n_bad++;
      $display("FAIL reset_outputs: code=%h en=%b err=%b dig=%0d required all zero", sCode, sEnter, sErrTecla, sDigitos);
    end
    reset = 1'b1;
  endtask

  task automatic test_basic;
    press(4'h4);
    n_cmp++;
    if (sDigitos !== 2'd1) begin n_bad++; $display("FAIL basic_dig1: sDigitos=%0d required 1", sDigitos); end
    press(4'h2);
    n_cmp++;
    if (sDigitos !== 2'd2) begin n_bad++; $display("FAIL basic_dig2: sDigitos=%0d required 2", sDigitos); end
    exp_q.push_back(8'h42);
    press(TECLA_ENTER);
    n_cmp++;
    if (sEnter !== 1'b1 || sCode !== 8'h42 || sDigitos !== 2'd0) begin
      n_bad++;
      $display("FAIL basic_enter: en=%b code=%h dig=%0d required 1 42 0", sEnter, sCode, sDigitos);
    end
    @(negedge clock);
    n_cmp++;
    if (sEnter !== 1'b0) begin n_bad++; $display("FAIL basic_pulse_len: sEnter=%b required 0", sEnter); end
  endtask

  task automatic test_three_digits;
    press(4'h1);
    press(4'h2);
    press(4'h3);
    exp_q.push_back(8'h23);
    press(TECLA_ENTER);
    n_cmp++;
    if (sCode !== 8'h23) begin n_bad++; $display("FAIL three_code: sCode=%h required 23", sCode); end
    press(4'h7);
    press(TECLA_ENTER);
    n_cmp++;
    if (sErrTecla !== 1'b1 || sEnter !== 1'b0 || sCode !== 8'h23) begin
      n_bad++;
      $display("FAIL short_entry: err=%b en=%b code=%h required 1 0 23", sErrTecla, sEnter, sCode);
    end
    @(negedge clock);
    n_cmp++;
    if (sErrTecla !== 1'b0) begin n_bad++; $display("FAIL short_pulse_len: sErrTecla=%b required 0", sErrTecla); end
  endtask

  task automatic test_timeout;
    press(4'h5);
    for (int i = 1; i <= 15; i++) begin
      @(negedge clock);
      n_cmp++;
      if (sErrTecla !== 1'b0 || sDigitos !== 2'd1) begin
        n_bad++;
        $display("FAIL timeout_early: cycle %0d err=%b dig=%0d required 0 1", i, sErrTecla, sDigitos);
      end
    end
    @(negedge clock);
    n_cmp++;
    if (sErrTecla !== 1'b1 || sDigitos !== 2'd0) begin
      n_bad++;
      $display("FAIL timeout_fire: err=%b dig=%0d required 1 0", sErrTecla, sDigitos);
    end
    press(4'h9);
    press(4'h1);
    exp_q.push_back(8'h91);
    press(TECLA_ENTER);
    n_cmp++;
    if (sCode !== 8'h91) begin n_bad++; $display("FAIL timeout_next_code: sCode=%h required 91", sCode); end
  endtask

  task automatic test_bloq;
    sBloq = 1'b1;
    press(4'h4);
    press(4'h2);
    press(TECLA_ENTER);
    n_cmp++;
    if (sDigitos !== 2'd0 || sEnter !== 1'b0 || sErrTecla !== 1'b0 || sCode !== 8'h91) begin
      n_bad++;
      $display("FAIL bloq_ignore: dig=%0d en=%b err=%b code=%h required 0 0 0 91", sDigitos, sEnter, sErrTecla, sCode);
    end
    sBloq = 1'b0;
    press(4'h4);
    press(4'h2);
    exp_q.push_back(8'h42);
    press(TECLA_ENTER);
    n_cmp++;
    if (sCode !== 8'h42) begin n_bad++; $display("FAIL bloq_after: sCode=%h required 42", sCode); end
  endtask

  task automatic test_async_reset;
    press(4'h3);
    n_cmp++;
    if (sDigitos !== 2'd1) begin n_bad++; $display("FAIL arst_pre: sDigitos=%0d required 1", sDigitos); end
    @(posedge clock);
    #2 reset = 1'b0;
    #1;
    n_cmp++;
    if ({sCode, sEnter, sErrTecla, sDigitos} !== 12'h000) begin
      n_bad++;
      $display("FAIL arst_immediate: code=%h en=%b err=%b dig=%0d required all zero", sCode, sEnter, sErrTecla, sDigitos);
    end
    @(negedge clock);
    reset = 1'b1;
    press(TECLA_ENTER);
    n_cmp++;
    if (sErrTecla !== 1'b1 || sEnter !== 1'b0) begin
      n_bad++;
      $display("FAIL arst_enter: err=%b en=%b required 1 0", sErrTecla, sEnter);
    end
  endtask

  task automatic test_invalid_and_race;
    press(4'h3);
    press(4'hE);
    n_cmp++;
    if (sErrTecla !== 1'b1 || sDigitos !== 2'd1) begin
      n_bad++;
      $display("FAIL invalid_key: err=%b dig=%0d required 1 1", sErrTecla, sDigitos);
    end
    repeat (15) @(negedge clock);
    press(4'h8);
    n_cmp++;
    if (sErrTecla !== 1'b0 || sDigitos !== 2'd2) begin
      n_bad++;
      $display("FAIL expiry_race: err=%b dig=%0d required 0 2", sErrTecla, sDigitos);
    end
    press(TECLA_BORRAR);
    n_cmp++;
    if (sErrTecla !== 1'b0 || sDigitos !== 2'd0) begin
      n_bad++;
      $display("FAIL clear_key: err=%b dig=%0d required 0 0", sErrTecla, sDigitos);
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_three_digits;
    test_timeout;
    test_bloq;
    test_async_reset;
    test_invalid_and_race;
    repeat (3) @(negedge clock);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL missing_enter: %0d pending submissions, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
